// File: rtl/mem_writer_pkg.sv
// Shared definitions for the mem_writer result flush path: FSM state
// encoding and the default dot-product result width.
package mem_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } writer_state_e;

    // Plain constants used by the state register so it stays a bare vector
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam int RESULT_COUNT_WIDTH = 3;

    function automatic int calc_result_width(input int data_width, input int vector_width);
        return 2 * data_width + $clog2(vector_width);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small circular FIFO buffering truncated results until the next flush.
// Pushes while full are dropped; the head is read straight from storage.
module result_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work too
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_writer.sv
// Buffers dot-product results on rising edges of result_valid and, on a
// rising edge of processing_done, streams them out to memory one word per cycle.
module mem_writer
    import mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int MEM_SIZE     = 64,
    parameter int RESULT_WIDTH = calc_result_width(DATA_WIDTH, VECTOR_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RESULT_WIDTH-1:0]       dot_product_result,
    input  logic                          result_valid,
    input  logic                          processing_done,
    output logic                          write_en,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          writer_busy,
    output logic                          writer_done,
    output logic [RESULT_COUNT_WIDTH-1:0] result_count
);

    localparam int ADDR_SPAN = (MEM_SIZE < (1 << ADDR_WIDTH)) ? MEM_SIZE : (1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_SPAN - 1);
    localparam int CNT_W = $clog2(VECTOR_WIDTH + 1);

    logic [1:0]            state;
    logic                  valid_q;
    logic                  done_q;
    logic                  push_evt;
    logic                  flush_evt;
    logic                  pop;
    logic                  last_entry;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] data_hold;

    if (RESULT_WIDTH > DATA_WIDTH) begin : g_trunc
        logic unused_upper_bits;
        assign unused_upper_bits = ^dot_product_result[RESULT_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= result_valid;
            done_q  <= processing_done;
        end
    end

    assign push_evt  = result_valid && !valid_q;
    assign flush_evt = processing_done && !done_q;
    assign pop       = (state == ST_WRITE) && !fifo_empty;

    // A push landing on the final pop keeps the flush going one more word
    assign last_entry = (fifo_count == CNT_W'(1)) && !(push_evt && !fifo_full);

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (VECTOR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_evt),
        .push_data (dot_product_result[DATA_WIDTH-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_evt) begin
                        state <= (fifo_count != '0) ? ST_WRITE : ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (last_entry) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Hold registers keep the last written word visible between flushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt  <= '0;
            addr_hold <= '0;
            data_hold <= '0;
        end else if (pop) begin
            addr_hold <= addr_cnt;
            data_hold <= fifo_head;
            addr_cnt  <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        end
    end

    assign write_en      = (state == ST_WRITE);
    assign writer_busy   = (state == ST_WRITE);
    assign writer_done   = (state == ST_DONE);
    assign write_address = write_en ? addr_cnt : addr_hold;
    assign data_in       = write_en ? fifo_head : data_hold;
    assign result_count  = RESULT_COUNT_WIDTH'(fifo_count);

endmodule

// File: tb/tb_mem_writer.sv
// Directed-plus-random bench for mem_writer, checked against a queue model
// of the result buffer and a modulo address counter.
module tb_mem_writer;

    localparam int DW   = 8;
    localparam int VW   = 4;
    localparam int AW   = 4;
    localparam int MS   = 64;
    localparam int RW   = 2 * DW + $clog2(VW);
    localparam int SPAN = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] dot_product_result = '0;
    logic          result_valid = 1'b0;
    logic          processing_done = 1'b0;
    logic          write_en;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_in;
    logic          writer_busy;
    logic          writer_done;
    logic [2:0]    result_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    int            model_addr = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    mem_writer #(
        .DATA_WIDTH   (DW),
        .VECTOR_WIDTH (VW),
        .ADDR_WIDTH   (AW),
        .MEM_SIZE     (MS),
        .RESULT_WIDTH (RW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dot_product_result (dot_product_result),
        .result_valid       (result_valid),
        .processing_done    (processing_done),
        .write_en           (write_en),
        .write_address      (write_address),
        .data_in            (data_in),
        .writer_busy        (writer_busy),
        .writer_done        (writer_done),
        .result_count       (result_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_addr = 0;
        last_addr  = '0;
        last_data  = '0;
    endtask

    task automatic check_reset_values();
        check_output("rst_write_en", write_en, 0);
        check_output("rst_busy", writer_busy, 0);
        check_output("rst_done", writer_done, 0);
        check_output("rst_count", result_count, 0);
        check_output("rst_addr", write_address, 0);
        check_output("rst_data", data_in, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        result_valid = 1'b0;
        processing_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        check_reset_values();
    endtask

    task automatic push_value(input logic [RW-1:0] v);
        dot_product_result = v;
        result_valid = 1'b1;
        tick();
        if (model_q.size() < VW) model_q.push_back(v[DW-1:0]);
        check_output("push_count", result_count, model_q.size());
        result_valid = 1'b0;
        tick();
    endtask

    // stir=1 adds random pushes and ignored flush edges while words are written
    task automatic run_flush(input bit stir);
        int  guard;
        bit  vprev;
        bit  do_push;
        bit  was_full;
        guard = 0;
        vprev = 1'b0;
        processing_done = 1'b1;
        tick();
        processing_done = 1'b0;
        if (model_q.size() == 0) begin
            check_output("empty_done", writer_done, 1);
            check_output("empty_we", write_en, 0);
            check_output("empty_busy", writer_busy, 0);
        end else begin
            while (model_q.size() > 0 && guard < 32) begin
                guard++;
                check_output("wr_en", write_en, 1);
                check_output("wr_busy", writer_busy, 1);
                check_output("wr_done", writer_done, 0);
                check_output("wr_addr", write_address, model_addr);
                check_output("wr_data", data_in, model_q[0]);
                check_output("wr_count", result_count, model_q.size());
                last_addr  = AW'(model_addr);
                last_data  = model_q[0];
                model_addr = (model_addr + 1) % SPAN;
                do_push = stir && !vprev && ($urandom_range(0, 1) == 1);
                result_valid = do_push;
                if (do_push) dot_product_result = RW'($urandom);
                was_full = (model_q.size() == VW);
                void'(model_q.pop_front());
                if (do_push && !was_full) model_q.push_back(dot_product_result[DW-1:0]);
                vprev = do_push;
                if (stir) processing_done = ($urandom_range(0, 1) == 1);
                tick();
            end
            result_valid = 1'b0;
            processing_done = 1'b0;
            check_output("fin_done", writer_done, 1);
            check_output("fin_we", write_en, 0);
            check_output("fin_busy", writer_busy, 0);
            check_output("fin_count", result_count, 0);
            check_output("hold_addr", write_address, last_addr);
            check_output("hold_data", data_in, last_data);
        end
        tick();
        check_output("post_done", writer_done, 0);
        check_output("post_we", write_en, 0);
        check_output("post_busy", writer_busy, 0);
    endtask

    initial begin
        logic [RW-1:0] seq_vals [5];
        seq_vals = '{RW'(60), RW'(3), RW'(255), RW'(1020), RW'(65535)};

        apply_reset();

        push_value(RW'(10));
        run_flush(1'b0);

        for (int i = 0; i < 5; i++) begin
            push_value(seq_vals[i]);
            run_flush(1'b0);
        end

        // A level held high is a single push
        dot_product_result = RW'(7);
        result_valid = 1'b1;
        tick();
        tick();
        tick();
        result_valid = 1'b0;
        model_q.push_back(DW'(7));
        tick();
        check_output("held_valid_count", result_count, 1);
        run_flush(1'b0);

        for (int i = 0; i < 6; i++) push_value(RW'($urandom));
        check_output("overflow_count", result_count, VW);
        run_flush(1'b0);

        run_flush(1'b0);

        // Reset in the middle of a flush
        for (int i = 0; i < 3; i++) push_value(RW'($urandom));
        processing_done = 1'b1;
        tick();
        processing_done = 1'b0;
        check_output("abort_we", write_en, 1);
        check_output("abort_data", data_in, model_q[0]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_reset_values();
        tick();
        check_output("abort_no_done", writer_done, 0);
        check_output("abort_idle_count", result_count, 0);

        for (int i = 0; i < 17; i++) begin
            push_value(RW'($urandom));
            run_flush(1'b0);
        end

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) push_value(RW'($urandom));
            run_flush(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
